// File: rtl/tl_uncached_pkg.sv
// Shared TileLink uncached encodings and address constants.
package tl_uncached_pkg;

    // Acquire types (built-in)
    localparam logic [2:0] A_GET       = 3'd0;
    localparam logic [2:0] A_PUT_BLOCK = 3'd3;

    // Grant types (built-in)
    localparam logic [3:0] G_VOL_ACK            = 4'd0;
    localparam logic [3:0] G_GET_DATA_BEAT_ACK  = 4'd3;
    localparam logic [3:0] G_GET_BLOCK_ACK      = 4'd4;

    // A block is 64 bytes, so byte address = addr_block << 6
    localparam int ADDR_SHIFT = 6;

endpackage

// File: rtl/tl_finish_queue.sv
// Small FIFO holding finish messages until the network accepts them.
module tl_finish_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because empty gates the output valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/client_uncached_network_port_mc.sv
// Uncached client to network port: routes acquires by address region,
// forwards grants, and queues finish messages for multiple managers.
module client_uncached_network_port_mc
    import tl_uncached_pkg::*;
#(
    parameter int                        ADDR_BLK_W   = 26,
    parameter int                        BEAT_W       = 3,
    parameter int                        DATA_W       = 64,
    parameter int                        UNION_W      = 12,
    parameter int                        MXID_W       = 2,
    parameter int                        HDR_W        = 2,
    parameter int                        CLIENT_ID    = 1,
    parameter int                        NUM_REGIONS  = 2,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE  = {32'h90000000, 32'h80000000},
    parameter logic [NUM_REGIONS*32-1:0] REGION_MASK  = {32'hF0000000, 32'hF0000000},
    parameter logic [NUM_REGIONS*HDR_W-1:0] REGION_DST = {2'd2, 2'd0},
    parameter int                        DEFAULT_DST  = 1,
    parameter int                        MAX_INFLIGHT = 4,
    parameter int                        FIN_DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    output logic                  io_client_acquire_ready,
    input  logic                  io_client_acquire_valid,
    input  logic [ADDR_BLK_W-1:0] io_client_acquire_bits_addr_block,
    input  logic                  io_client_acquire_bits_client_xact_id,
    input  logic [BEAT_W-1:0]     io_client_acquire_bits_addr_beat,
    input  logic                  io_client_acquire_bits_is_builtin_type,
    input  logic [2:0]            io_client_acquire_bits_a_type,
    input  logic [UNION_W-1:0]    io_client_acquire_bits_union,
    input  logic [DATA_W-1:0]     io_client_acquire_bits_data,

    input  logic                  io_client_grant_ready,
    output logic                  io_client_grant_valid,
    output logic [BEAT_W-1:0]     io_client_grant_bits_addr_beat,
    output logic                  io_client_grant_bits_client_xact_id,
    output logic [MXID_W-1:0]     io_client_grant_bits_manager_xact_id,
    output logic                  io_client_grant_bits_is_builtin_type,
    output logic [3:0]            io_client_grant_bits_g_type,
    output logic [DATA_W-1:0]     io_client_grant_bits_data,

    input  logic                  io_network_acquire_ready,
    output logic                  io_network_acquire_valid,
    output logic [HDR_W-1:0]      io_network_acquire_bits_header_src,
    output logic [HDR_W-1:0]      io_network_acquire_bits_header_dst,
    output logic [ADDR_BLK_W-1:0] io_network_acquire_bits_payload_addr_block,
    output logic                  io_network_acquire_bits_payload_client_xact_id,
    output logic [BEAT_W-1:0]     io_network_acquire_bits_payload_addr_beat,
    output logic                  io_network_acquire_bits_payload_is_builtin_type,
    output logic [2:0]            io_network_acquire_bits_payload_a_type,
    output logic [UNION_W-1:0]    io_network_acquire_bits_payload_union,
    output logic [DATA_W-1:0]     io_network_acquire_bits_payload_data,

    output logic                  io_network_grant_ready,
    input  logic                  io_network_grant_valid,
    input  logic [HDR_W-1:0]      io_network_grant_bits_header_src,
    input  logic [HDR_W-1:0]      io_network_grant_bits_header_dst,
    input  logic [BEAT_W-1:0]     io_network_grant_bits_payload_addr_beat,
    input  logic                  io_network_grant_bits_payload_client_xact_id,
    input  logic [MXID_W-1:0]     io_network_grant_bits_payload_manager_xact_id,
    input  logic                  io_network_grant_bits_payload_is_builtin_type,
    input  logic [3:0]            io_network_grant_bits_payload_g_type,
    input  logic [DATA_W-1:0]     io_network_grant_bits_payload_data,

    input  logic                  io_network_finish_ready,
    output logic                  io_network_finish_valid,
    output logic [HDR_W-1:0]      io_network_finish_bits_header_src,
    output logic [HDR_W-1:0]      io_network_finish_bits_header_dst,
    output logic [MXID_W-1:0]     io_network_finish_bits_payload_manager_xact_id,

    output logic                  io_network_probe_ready,
    output logic                  io_network_release_valid,
    input  logic                  io_network_release_ready
);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam int FIN_W = 2 * HDR_W + MXID_W;

    logic [INF_W-1:0] inflight;
    logic             mid_burst;
    logic [HDR_W-1:0] dst_lock;
    logic [HDR_W-1:0] route_dst;
    logic [31:0]      byte_addr;
    logic             can_issue;
    logic             acq_fire;
    logic             acq_is_put;
    logic             acq_last_beat;
    logic             acq_count;

    logic             need_fin;
    logic             last_gnt;
    logic             gnt_gate;
    logic             gnt_fire;
    logic             gnt_last_fire;
    logic             gnt_dec;

    logic             fin_full;
    logic             fin_empty;
    logic             fin_push;
    logic [FIN_W-1:0] fin_push_data;
    logic [FIN_W-1:0] fin_head;

    logic             unused_inputs;
    assign unused_inputs = &{1'b0, io_network_release_ready};

    // ---------------- acquire path ----------------
    assign byte_addr = 32'(io_client_acquire_bits_addr_block) << ADDR_SHIFT;

    // Region lookup; scanning high to low lets the lowest hitting index win.
    always_comb begin
        route_dst = HDR_W'(DEFAULT_DST);
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((byte_addr & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32]) begin
                route_dst = REGION_DST[HDR_W*i +: HDR_W];
            end
        end
    end

    assign acq_is_put    = io_client_acquire_bits_is_builtin_type &&
                           (io_client_acquire_bits_a_type == A_PUT_BLOCK);
    assign acq_last_beat = !acq_is_put || (&io_client_acquire_bits_addr_beat);
    assign can_issue     = (inflight < INF_W'(MAX_INFLIGHT)) || mid_burst;
    assign acq_fire      = io_client_acquire_valid && io_network_acquire_ready && can_issue;
    assign acq_count     = acq_fire && acq_last_beat;

    assign io_client_acquire_ready  = io_network_acquire_ready & can_issue;
    assign io_network_acquire_valid = io_client_acquire_valid & can_issue;

    assign io_network_acquire_bits_header_src = HDR_W'(CLIENT_ID);
    assign io_network_acquire_bits_header_dst = mid_burst ? dst_lock : route_dst;
    assign io_network_acquire_bits_payload_addr_block      = io_client_acquire_bits_addr_block;
    assign io_network_acquire_bits_payload_client_xact_id  = io_client_acquire_bits_client_xact_id;
    assign io_network_acquire_bits_payload_addr_beat       = io_client_acquire_bits_addr_beat;
    assign io_network_acquire_bits_payload_is_builtin_type = io_client_acquire_bits_is_builtin_type;
    assign io_network_acquire_bits_payload_a_type          = io_client_acquire_bits_a_type;
    assign io_network_acquire_bits_payload_union           = io_client_acquire_bits_union;
    assign io_network_acquire_bits_payload_data            = io_client_acquire_bits_data;

    // Burst tracking: destination is captured on the first putBlock beat so
    // every beat of the block lands on the same manager.
    always_ff @(posedge clk) begin
        if (reset) begin
            mid_burst <= 1'b0;
            dst_lock  <= '0;
        end else if (acq_fire && acq_is_put) begin
            if (acq_last_beat) begin
                mid_burst <= 1'b0;
            end else begin
                mid_burst <= 1'b1;
                if (!mid_burst) dst_lock <= route_dst;
            end
        end
    end

    // ---------------- grant path ----------------
    assign need_fin = !(io_network_grant_bits_payload_is_builtin_type &&
                        (io_network_grant_bits_payload_g_type == G_VOL_ACK));
    assign last_gnt = !(io_network_grant_bits_payload_is_builtin_type &&
                        (io_network_grant_bits_payload_g_type == G_GET_BLOCK_ACK)) ||
                      (&io_network_grant_bits_payload_addr_beat);
    assign gnt_gate = !(need_fin && last_gnt && fin_full);

    assign io_client_grant_valid  = io_network_grant_valid & gnt_gate;
    assign io_network_grant_ready = io_client_grant_ready & gnt_gate;
    assign gnt_fire      = io_network_grant_valid && io_client_grant_ready && gnt_gate;
    assign gnt_last_fire = gnt_fire && last_gnt;
    assign gnt_dec       = gnt_last_fire && (inflight != '0);

    assign io_client_grant_bits_addr_beat       = io_network_grant_bits_payload_addr_beat;
    assign io_client_grant_bits_client_xact_id  = io_network_grant_bits_payload_client_xact_id;
    assign io_client_grant_bits_manager_xact_id = io_network_grant_bits_payload_manager_xact_id;
    assign io_client_grant_bits_is_builtin_type = io_network_grant_bits_payload_is_builtin_type;
    assign io_client_grant_bits_g_type          = io_network_grant_bits_payload_g_type;
    assign io_client_grant_bits_data            = io_network_grant_bits_payload_data;

    // Outstanding transaction count; a grant that arrives with nothing
    // outstanding is ignored here and caught by the assertion below.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({acq_count, gnt_dec})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
                                     !(gnt_last_fire && (inflight == '0)));

    // ---------------- finish path ----------------
    // Finish goes back to the granting manager: swap the grant header.
    assign fin_push      = gnt_last_fire && need_fin;
    assign fin_push_data = {io_network_grant_bits_header_src,
                            io_network_grant_bits_header_dst,
                            io_network_grant_bits_payload_manager_xact_id};

    tl_finish_queue #(
        .DEPTH (FIN_DEPTH),
        .WIDTH (FIN_W)
    ) u_finish_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (fin_push),
        .push_data (fin_push_data),
        .pop       (io_network_finish_ready),
        .pop_data  (fin_head),
        .full      (fin_full),
        .empty     (fin_empty)
    );

    assign io_network_finish_valid = !fin_empty;
    assign {io_network_finish_bits_header_dst,
            io_network_finish_bits_header_src,
            io_network_finish_bits_payload_manager_xact_id} = fin_head;

    assign io_network_probe_ready   = 1'b0;
    assign io_network_release_valid = 1'b0;

endmodule

// File: tb/tb_client_uncached_network_port_mc.sv
// Directed bench for client_uncached_network_port_mc with default parameters.
module tb_client_uncached_network_port_mc;
    import tl_uncached_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        io_client_acquire_ready;
    logic        io_client_acquire_valid;
    logic [25:0] io_client_acquire_bits_addr_block;
    logic        io_client_acquire_bits_client_xact_id;
    logic [2:0]  io_client_acquire_bits_addr_beat;
    logic        io_client_acquire_bits_is_builtin_type;
    logic [2:0]  io_client_acquire_bits_a_type;
    logic [11:0] io_client_acquire_bits_union;
    logic [63:0] io_client_acquire_bits_data;

    logic        io_client_grant_ready;
    logic        io_client_grant_valid;
    logic [2:0]  io_client_grant_bits_addr_beat;
    logic        io_client_grant_bits_client_xact_id;
    logic [1:0]  io_client_grant_bits_manager_xact_id;
    logic        io_client_grant_bits_is_builtin_type;
    logic [3:0]  io_client_grant_bits_g_type;
    logic [63:0] io_client_grant_bits_data;

    logic        io_network_acquire_ready;
    logic        io_network_acquire_valid;
    logic [1:0]  io_network_acquire_bits_header_src;
    logic [1:0]  io_network_acquire_bits_header_dst;
    logic [25:0] io_network_acquire_bits_payload_addr_block;
    logic        io_network_acquire_bits_payload_client_xact_id;
    logic [2:0]  io_network_acquire_bits_payload_addr_beat;
    logic        io_network_acquire_bits_payload_is_builtin_type;
    logic [2:0]  io_network_acquire_bits_payload_a_type;
    logic [11:0] io_network_acquire_bits_payload_union;
    logic [63:0] io_network_acquire_bits_payload_data;

    logic        io_network_grant_ready;
    logic        io_network_grant_valid;
    logic [1:0]  io_network_grant_bits_header_src;
    logic [1:0]  io_network_grant_bits_header_dst;
    logic [2:0]  io_network_grant_bits_payload_addr_beat;
    logic        io_network_grant_bits_payload_client_xact_id;
    logic [1:0]  io_network_grant_bits_payload_manager_xact_id;
    logic        io_network_grant_bits_payload_is_builtin_type;
    logic [3:0]  io_network_grant_bits_payload_g_type;
    logic [63:0] io_network_grant_bits_payload_data;

    logic        io_network_finish_ready;
    logic        io_network_finish_valid;
    logic [1:0]  io_network_finish_bits_header_src;
    logic [1:0]  io_network_finish_bits_header_dst;
    logic [1:0]  io_network_finish_bits_payload_manager_xact_id;

    logic        io_network_probe_ready;
    logic        io_network_release_valid;
    logic        io_network_release_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    client_uncached_network_port_mc dut (
        .clk (clk),
        .reset (reset),
        .io_client_acquire_ready (io_client_acquire_ready),
        .io_client_acquire_valid (io_client_acquire_valid),
        .io_client_acquire_bits_addr_block (io_client_acquire_bits_addr_block),
        .io_client_acquire_bits_client_xact_id (io_client_acquire_bits_client_xact_id),
        .io_client_acquire_bits_addr_beat (io_client_acquire_bits_addr_beat),
        .io_client_acquire_bits_is_builtin_type (io_client_acquire_bits_is_builtin_type),
        .io_client_acquire_bits_a_type (io_client_acquire_bits_a_type),
        .io_client_acquire_bits_union (io_client_acquire_bits_union),
        .io_client_acquire_bits_data (io_client_acquire_bits_data),
        .io_client_grant_ready (io_client_grant_ready),
        .io_client_grant_valid (io_client_grant_valid),
        .io_client_grant_bits_addr_beat (io_client_grant_bits_addr_beat),
        .io_client_grant_bits_client_xact_id (io_client_grant_bits_client_xact_id),
        .io_client_grant_bits_manager_xact_id (io_client_grant_bits_manager_xact_id),
        .io_client_grant_bits_is_builtin_type (io_client_grant_bits_is_builtin_type),
        .io_client_grant_bits_g_type (io_client_grant_bits_g_type),
        .io_client_grant_bits_data (io_client_grant_bits_data),
        .io_network_acquire_ready (io_network_acquire_ready),
        .io_network_acquire_valid (io_network_acquire_valid),
        .io_network_acquire_bits_header_src (io_network_acquire_bits_header_src),
        .io_network_acquire_bits_header_dst (io_network_acquire_bits_header_dst),
        .io_network_acquire_bits_payload_addr_block (io_network_acquire_bits_payload_addr_block),
        .io_network_acquire_bits_payload_client_xact_id (io_network_acquire_bits_payload_client_xact_id),
        .io_network_acquire_bits_payload_addr_beat (io_network_acquire_bits_payload_addr_beat),
        .io_network_acquire_bits_payload_is_builtin_type (io_network_acquire_bits_payload_is_builtin_type),
        .io_network_acquire_bits_payload_a_type (io_network_acquire_bits_payload_a_type),
        .io_network_acquire_bits_payload_union (io_network_acquire_bits_payload_union),
        .io_network_acquire_bits_payload_data (io_network_acquire_bits_payload_data),
        .io_network_grant_ready (io_network_grant_ready),
        .io_network_grant_valid (io_network_grant_valid),
        .io_network_grant_bits_header_src (io_network_grant_bits_header_src),
        .io_network_grant_bits_header_dst (io_network_grant_bits_header_dst),
        .io_network_grant_bits_payload_addr_beat (io_network_grant_bits_payload_addr_beat),
        .io_network_grant_bits_payload_client_xact_id (io_network_grant_bits_payload_client_xact_id),
        .io_network_grant_bits_payload_manager_xact_id (io_network_grant_bits_payload_manager_xact_id),
        .io_network_grant_bits_payload_is_builtin_type (io_network_grant_bits_payload_is_builtin_type),
        .io_network_grant_bits_payload_g_type (io_network_grant_bits_payload_g_type),
        .io_network_grant_bits_payload_data (io_network_grant_bits_payload_data),
        .io_network_finish_ready (io_network_finish_ready),
        .io_network_finish_valid (io_network_finish_valid),
        .io_network_finish_bits_header_src (io_network_finish_bits_header_src),
        .io_network_finish_bits_header_dst (io_network_finish_bits_header_dst),
        .io_network_finish_bits_payload_manager_xact_id (io_network_finish_bits_payload_manager_xact_id),
        .io_network_probe_ready (io_network_probe_ready),
        .io_network_release_valid (io_network_release_valid),
        .io_network_release_ready (io_network_release_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_acq(input logic [25:0] blk, input logic [2:0] atype, input logic [2:0] beat);
        io_client_acquire_valid                = 1'b1;
        io_client_acquire_bits_addr_block      = blk;
        io_client_acquire_bits_is_builtin_type = 1'b1;
        io_client_acquire_bits_a_type          = atype;
        io_client_acquire_bits_addr_beat       = beat;
        io_client_acquire_bits_data            = {61'd0, beat};
    endtask

    task automatic drive_gnt(input logic [3:0] gtype, input logic [2:0] beat, input logic [1:0] mxid,
                             input logic [1:0] hsrc, input logic [1:0] hdst);
        io_network_grant_valid                        = 1'b1;
        io_network_grant_bits_payload_is_builtin_type = 1'b1;
        io_network_grant_bits_payload_g_type          = gtype;
        io_network_grant_bits_payload_addr_beat       = beat;
        io_network_grant_bits_payload_manager_xact_id = mxid;
        io_network_grant_bits_header_src              = hsrc;
        io_network_grant_bits_header_dst              = hdst;
        io_network_grant_bits_payload_data            = 64'hD000 + 64'(beat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        io_client_acquire_valid = 1'b0;
        io_client_acquire_bits_addr_block = '0;
        io_client_acquire_bits_client_xact_id = 1'b0;
        io_client_acquire_bits_addr_beat = '0;
        io_client_acquire_bits_is_builtin_type = 1'b0;
        io_client_acquire_bits_a_type = '0;
        io_client_acquire_bits_union = 12'h5A5;
        io_client_acquire_bits_data = '0;
        io_client_grant_ready = 1'b1;
        io_network_acquire_ready = 1'b1;
        io_network_grant_valid = 1'b0;
        io_network_grant_bits_header_src = '0;
        io_network_grant_bits_header_dst = '0;
        io_network_grant_bits_payload_addr_beat = '0;
        io_network_grant_bits_payload_client_xact_id = 1'b0;
        io_network_grant_bits_payload_manager_xact_id = '0;
        io_network_grant_bits_payload_is_builtin_type = 1'b0;
        io_network_grant_bits_payload_g_type = '0;
        io_network_grant_bits_payload_data = '0;
        io_network_finish_ready = 1'b0;
        io_network_release_ready = 1'b1;

        tick(); tick();
        reset = 1'b0;
        settle();
        check("rst_finish_valid",  64'(io_network_finish_valid), 64'd0);
        check("rst_release_valid", 64'(io_network_release_valid), 64'd0);
        check("rst_probe_ready",   64'(io_network_probe_ready), 64'd0);
        check("rst_inflight",      64'(dut.inflight), 64'd0);
        check("rst_acq_valid",     64'(io_network_acquire_valid), 64'd0);

        // Routing and the inflight limit
        drive_acq(26'h2000000, A_GET, 3'd0); settle();
        check("route_r0_valid", 64'(io_network_acquire_valid), 64'd1);
        check("route_r0_ready", 64'(io_client_acquire_ready), 64'd1);
        check("route_r0_dst",   64'(io_network_acquire_bits_header_dst), 64'd0);
        check("route_r0_src",   64'(io_network_acquire_bits_header_src), 64'd1);
        check("route_r0_addr",  64'(io_network_acquire_bits_payload_addr_block), 64'h2000000);
        check("route_r0_union", 64'(io_network_acquire_bits_payload_union), 64'h5A5);
        tick();
        drive_acq(26'h2400000, A_GET, 3'd0); settle();
        check("route_r1_dst", 64'(io_network_acquire_bits_header_dst), 64'd2);
        check("inflight_1",   64'(dut.inflight), 64'd1);
        tick();
        drive_acq(26'h0000000, A_GET, 3'd0); settle();
        check("route_def_dst", 64'(io_network_acquire_bits_header_dst), 64'd1);
        check("inflight_2",    64'(dut.inflight), 64'd2);
        tick();
        drive_acq(26'h3000000, A_GET, 3'd0); settle();
        check("route_def2_dst", 64'(io_network_acquire_bits_header_dst), 64'd1);
        tick();
        drive_acq(26'h2000000, A_GET, 3'd0); settle();
        check("limit_inflight",  64'(dut.inflight), 64'd4);
        check("limit_cli_ready", 64'(io_client_acquire_ready), 64'd0);
        check("limit_net_valid", 64'(io_network_acquire_valid), 64'd0);
        tick(); settle();
        check("limit_hold_ready", 64'(io_client_acquire_ready), 64'd0);

        drive_gnt(G_GET_DATA_BEAT_ACK, 3'd0, 2'd1, 2'd0, 2'd1); settle();
        check("beatack_cli_valid", 64'(io_client_grant_valid), 64'd1);
        check("beatack_net_ready", 64'(io_network_grant_ready), 64'd1);
        check("beatack_data",      io_client_grant_bits_data, 64'hD000);
        check("beatack_mxid",      64'(io_client_grant_bits_manager_xact_id), 64'd1);
        tick();
        io_network_grant_valid = 1'b0; settle();
        check("after_gnt_inflight", 64'(dut.inflight), 64'd3);
        check("after_gnt_acq_ready", 64'(io_client_acquire_ready), 64'd1);
        check("fin1_valid", 64'(io_network_finish_valid), 64'd1);
        check("fin1_dst",   64'(io_network_finish_bits_header_dst), 64'd0);
        check("fin1_src",   64'(io_network_finish_bits_header_src), 64'd1);
        check("fin1_mxid",  64'(io_network_finish_bits_payload_manager_xact_id), 64'd1);
        tick();
        io_client_acquire_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            drive_gnt(G_VOL_ACK, 3'd0, 2'd0, 2'd0, 2'd1); settle();
            check("volack_ready", 64'(io_network_grant_ready), 64'd1);
            tick();
        end
        io_network_grant_valid = 1'b0; settle();
        check("drain_inflight",  64'(dut.inflight), 64'd0);
        check("volack_no_fin",   64'(io_network_finish_bits_payload_manager_xact_id), 64'd1);

        // putBlock with a stall mid-burst; later beats point at region 0
        for (int b = 0; b < 8; b++) begin
            drive_acq((b == 0) ? 26'h0000100 : 26'h2000000, A_PUT_BLOCK, 3'(b)); settle();
            check("put_dst",      64'(io_network_acquire_bits_header_dst), 64'd1);
            check("put_inflight", 64'(dut.inflight), 64'd0);
            if (b == 3) begin
                io_network_acquire_ready = 1'b0; settle();
                check("put_stall_ready", 64'(io_client_acquire_ready), 64'd0);
                check("put_stall_valid", 64'(io_network_acquire_valid), 64'd1);
                tick();
                io_network_acquire_ready = 1'b1; settle();
                check("put_stall_dst", 64'(io_network_acquire_bits_header_dst), 64'd1);
            end
            tick();
        end
        io_client_acquire_valid = 1'b0; settle();
        check("put_done_inflight", 64'(dut.inflight), 64'd1);
        check("put_done_burst",    64'(dut.mid_burst), 64'd0);

        // 8-beat block grant
        for (int b = 0; b < 8; b++) begin
            drive_gnt(G_GET_BLOCK_ACK, 3'(b), 2'd2, 2'd2, 2'd1); settle();
            check("blk_cli_valid", 64'(io_client_grant_valid), 64'd1);
            check("blk_beat",      64'(io_client_grant_bits_addr_beat), 64'(b));
            check("blk_data",      io_client_grant_bits_data, 64'hD000 + 64'(b));
            check("blk_inflight",  64'(dut.inflight), 64'd1);
            tick();
        end
        io_network_grant_valid = 1'b0; settle();
        check("blk_done_inflight", 64'(dut.inflight), 64'd0);

        // FIFO now full: a further last grant must stall
        drive_acq(26'h0, A_GET, 3'd0); tick();
        io_client_acquire_valid = 1'b0;
        drive_gnt(G_GET_DATA_BEAT_ACK, 3'd0, 2'd3, 2'd1, 2'd1); settle();
        check("full_net_ready", 64'(io_network_grant_ready), 64'd0);
        check("full_cli_valid", 64'(io_client_grant_valid), 64'd0);
        tick(); settle();
        check("full_hold_ready", 64'(io_network_grant_ready), 64'd0);
        io_network_finish_ready = 1'b1; settle();
        check("full_deq_ready", 64'(io_network_grant_ready), 64'd0);
        check("head1_mxid",     64'(io_network_finish_bits_payload_manager_xact_id), 64'd1);
        tick();
        io_network_finish_ready = 1'b0; settle();
        check("head2_dst",  64'(io_network_finish_bits_header_dst), 64'd2);
        check("head2_src",  64'(io_network_finish_bits_header_src), 64'd1);
        check("head2_mxid", 64'(io_network_finish_bits_payload_manager_xact_id), 64'd2);
        check("unstall_ready", 64'(io_network_grant_ready), 64'd1);
        tick();
        io_network_grant_valid = 1'b0;
        io_network_finish_ready = 1'b1; settle();
        check("unstall_inflight", 64'(dut.inflight), 64'd0);
        tick(); settle();
        check("head3_dst",  64'(io_network_finish_bits_header_dst), 64'd1);
        check("head3_mxid", 64'(io_network_finish_bits_payload_manager_xact_id), 64'd3);
        tick();
        io_network_finish_ready = 1'b0; settle();
        check("fifo_empty", 64'(io_network_finish_valid), 64'd0);

        // Reset in the middle of a putBlock with a finish pending
        drive_acq(26'h0, A_GET, 3'd0); tick();
        io_client_acquire_valid = 1'b0;
        drive_gnt(G_GET_DATA_BEAT_ACK, 3'd0, 2'd0, 2'd2, 2'd1); tick();
        io_network_grant_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            drive_acq(26'h2400000, A_PUT_BLOCK, 3'(b)); tick();
        end
        drive_acq(26'h0, A_PUT_BLOCK, 3'd3); settle();
        check("lock_dst",       64'(io_network_acquire_bits_header_dst), 64'd2);
        check("pre_rst_finish", 64'(io_network_finish_valid), 64'd1);
        io_client_acquire_valid = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0; settle();
        check("rst2_finish_valid", 64'(io_network_finish_valid), 64'd0);
        check("rst2_inflight",     64'(dut.inflight), 64'd0);
        drive_acq(26'h0, A_GET, 3'd0); settle();
        check("rst2_fresh_dst", 64'(io_network_acquire_bits_header_dst), 64'd1);
        tick();
        io_client_acquire_valid = 1'b0; settle();
        check("rst2_inflight_1", 64'(dut.inflight), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
